// File: rtl/vx_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : vx_div_sched
//  Description : Round-robin scheduler that shares one iterative divider
//                among NUM_REQS requesters. One operation in flight at a time:
//                grant -> strobe -> wait for busy low -> hold response.
//  Revision    : 1.0  initial release
// ============================================================================
module vx_div_sched #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 130,
   parameter int RSPW     = 64,
   parameter int TAGW     = 16,
   localparam int IDXW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   output logic [NUM_REQS-1:0]       req_ready,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   input  logic [NUM_REQS*TAGW-1:0]  req_tag,
   output logic                      div_strobe,
   output logic [DATAW-1:0]          div_data,
   input  logic                      div_busy,
   input  logic [RSPW-1:0]           div_result,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDXW-1:0]           rsp_idx,
   output logic [TAGW-1:0]           rsp_tag,
   output logic [RSPW-1:0]           rsp_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDXW-1:0]   r_last;
   logic [IDXW-1:0]   r_idx;
   logic [TAGW-1:0]   r_tag;
   logic [DATAW-1:0]  r_data;
   logic [RSPW-1:0]   r_result;
   logic              r_wait_armed;   // low on the first WAIT cycle: divider busy may not have risen yet
   logic              w_any;
   logic [IDXW-1:0]   w_gnt_idx;
   logic [IDXW-1:0]   w_cand_idx;
   logic              w_grant;
   logic              w_latch;

   assign div_data = r_data;
   assign rsp_idx  = r_idx;
   assign rsp_tag  = r_tag;
   assign rsp_data = r_result;

   // Round-robin search: first valid requester after the last grantee, wrapping.
   always_comb begin
      w_any      = 1'b0;
      w_gnt_idx  = '0;
      w_cand_idx = '0;
      for (int i = 1; i <= NUM_REQS; i++) begin
         w_cand_idx = IDXW'((int'(r_last) + i) % NUM_REQS);
         if (!w_any && req_valid[w_cand_idx]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_cand_idx;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs; grants are suppressed while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      div_strobe  = 1'b0;
      rsp_valid   = 1'b0;
      w_grant     = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any && reset) begin
               req_ready[w_gnt_idx] = 1'b1;
               w_grant              = 1'b1;
               w_state_nxt          = S_ISSUE;
            end
         end
         S_ISSUE: begin
            div_strobe  = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait_armed && !div_busy) begin
               w_latch     = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand/tag capture on grant, result capture when the divider finishes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last       <= IDXW'(NUM_REQS - 1);
         r_idx        <= '0;
         r_tag        <= '0;
         r_data       <= '0;
         r_result     <= '0;
         r_wait_armed <= 1'b0;
      end else begin
         if (w_grant) begin
            r_last <= w_gnt_idx;
            r_idx  <= w_gnt_idx;
            r_tag  <= req_tag[w_gnt_idx*TAGW +: TAGW];
            r_data <= req_data[w_gnt_idx*DATAW +: DATAW];
         end
         r_wait_armed <= (r_state == S_WAIT);
         if (w_latch) begin
            r_result <= div_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vx_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_div_sched
//  Description : Randomized self-checking bench for vx_div_sched with a
//                transaction-level scheduler/divider reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vx_div_sched;
   localparam int N  = 4;
   localparam int DW = 130;
   localparam int RW = 64;
   localparam int TW = 16;
   localparam int IW = 2;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic [N*TW-1:0] req_tag;
   logic            div_strobe;
   logic [DW-1:0]   div_data;
   logic            div_busy;
   logic [RW-1:0]   div_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_idx;
   logic [TW-1:0]   rsp_tag;
   logic [RW-1:0]   rsp_data;

   vx_div_sched #(.NUM_REQS(N), .DATAW(DW), .RSPW(RW), .TAGW(TW)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .div_strobe (div_strobe),
      .div_data   (div_data),
      .div_busy   (div_busy),
      .div_result (div_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_idx    (rsp_idx),
      .rsp_tag    (rsp_tag),
      .rsp_data   (rsp_data)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Requester side: each holds valid/data/tag until its request is accepted.
   bit            rq_v[N];
   logic [DW-1:0] rq_d[N];
   logic [TW-1:0] rq_t[N];

   // Reference model: one operation in flight, described by its grant cycle
   // and the divider timing chosen for it.
   bit            m_busy = 1'b0;
   int            m_gc, m_late, m_len, m_rsp_c;
   int            m_last = N - 1;
   int            m_idx;
   logic [DW-1:0] m_d;
   logic [TW-1:0] m_t;
   logic [RW-1:0] m_res;

   // Stimulus knobs.
   logic [N-1:0]  p_mask  = '0;
   int            p_vprob = 0;
   int            p_rprob = 100;
   int            p_lmax  = 3;
   int            p_forcel = -1;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   // Divider busy for the in-flight operation: rises at grant+2 (+1 if late), lasts m_len cycles.
   function automatic bit busy_at(input int k);
      return m_busy && (k >= m_gc + 2 + m_late) && (k < m_gc + 2 + m_late + m_len);
   endfunction

   function automatic int rr_pick();
      int j;
      for (int k = 1; k <= N; k++) begin
         j = (m_last + k) % N;
         if (rq_v[j]) return j;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!rq_v[i] && p_mask[i] && ($urandom_range(99) < p_vprob)) begin
            rq_v[i] = 1'b1;
            rq_d[i] = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            rq_t[i] = TW'($urandom);
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = rq_v[i];
         req_data[i*DW +: DW]  = rq_d[i];
         req_tag[i*TW +: TW]   = rq_t[i];
      end
      rsp_ready  = ($urandom_range(99) < p_rprob);
      div_busy   = busy_at(cyc);
      // The true result is presented only on the cycle the scheduler must latch it.
      div_result = (m_busy && cyc == m_rsp_c - 1) ? m_res : RW'({$urandom, $urandom});
   endtask

   task automatic check();
      int           pk;
      logic [N-1:0] er;
      pk = rr_pick();
      er = '0;
      if (!m_busy && pk >= 0) er[pk] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("div_strobe", div_strobe, m_busy && cyc == m_gc + 1);
      if (m_busy) chk("div_data", div_data, m_d);
      chk("rsp_valid", rsp_valid, m_busy && cyc >= m_rsp_c);
      if (m_busy && cyc >= m_rsp_c) begin
         chk("rsp_idx", rsp_idx, m_idx);
         chk("rsp_tag", rsp_tag, m_t);
         chk("rsp_data", rsp_data, m_res);
      end
   endtask

   task automatic advance();
      int pk;
      int k;
      if (m_busy && cyc >= m_rsp_c && rsp_ready) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         pk = rr_pick();
         if (pk >= 0) begin
            m_busy   = 1'b1;
            m_gc     = cyc;
            m_last   = pk;
            m_idx    = pk;
            m_d      = rq_d[pk];
            m_t      = rq_t[pk];
            rq_v[pk] = 1'b0;
            m_res    = RW'({$urandom, $urandom});
            if (p_forcel >= 0) begin
               m_len  = p_forcel;
               m_late = 0;
            end else begin
               m_len  = $urandom_range(p_lmax);
               m_late = (m_len == 0) ? 0 : $urandom_range(1);
            end
            // Result is taken on the first busy-low cycle from the second WAIT cycle on.
            k = m_gc + 3;
            while (busy_at(k)) k++;
            m_rsp_c = k + 1;
         end
      end
   endtask

   task automatic step_body();
      cyc++;
      drive();
      #1;
      check();
      advance();
   endtask

   task automatic step();
      @(negedge clk);
      step_body();
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_req_ready"}, req_ready, '0);
      chk({pfx, "_div_strobe"}, div_strobe, 0);
      chk({pfx, "_rsp_valid"}, rsp_valid, 0);
      chk({pfx, "_rsp_idx"}, rsp_idx, 0);
      chk({pfx, "_rsp_tag"}, rsp_tag, 0);
      chk({pfx, "_rsp_data"}, rsp_data, 0);
      chk({pfx, "_div_data"}, div_data, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rq_v[i] = 1'b0;
         rq_d[i] = '0;
         rq_t[i] = '0;
      end
      req_valid  = '0;
      req_data   = '0;
      req_tag    = '0;
      rsp_ready  = 1'b0;
      div_busy   = 1'b0;
      div_result = '0;

      // Power-on reset.
      #12;
      chk_all_zero("por");
      @(negedge clk);
      reset = 1'b1;
      step_body();

      // Single request from requester 2, 33-cycle divide.
      rq_v[2]  = 1'b1;
      rq_t[2]  = 16'h00A5;
      rq_d[2]  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
      p_forcel = 33;
      repeat (45) step();

      // All requesters continuously valid: strict rotation.
      p_forcel = -1;
      p_mask   = 4'hF;
      p_vprob  = 100;
      p_lmax   = 3;
      repeat (80) step();

      // Response backpressure.
      p_rprob = 0;
      repeat (40) step();
      p_rprob = 100;
      repeat (10) step();

      // Random traffic, including late busy rise and zero-length divides.
      p_vprob = 30;
      p_rprob = 60;
      p_lmax  = 6;
      repeat (400) step();

      // Drain everything before the mid-operation reset scenario.
      p_mask  = '0;
      p_rprob = 100;
      for (int k = 0; k < 500 && (m_busy || rq_v[0] || rq_v[1] || rq_v[2] || rq_v[3]); k++) step();
      chk("drained", m_busy || rq_v[0] || rq_v[1] || rq_v[2] || rq_v[3], 0);

      // Reset asserted in the first WAIT cycle with requester 3 pending.
      rq_v[1]  = 1'b1;
      p_forcel = 20;
      for (int k = 0; k < 100 && !(m_busy && cyc == m_gc + 2); k++) step();
      chk("reach_wait", m_busy && cyc == m_gc + 2, 1);
      rq_v[3]      = 1'b1;
      req_valid[3] = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("rst");
      m_busy   = 1'b0;
      m_last   = N - 1;
      rq_v[0]  = ($urandom_range(1) == 1);
      req_valid[0] = rq_v[0];
      @(negedge clk);
      #1;
      chk_all_zero("rst_hold");
      @(negedge clk);
      reset    = 1'b1;
      p_forcel = -1;
      step_body();
      repeat (60) step();

      // More random traffic after the reset.
      p_mask  = 4'hF;
      p_vprob = 40;
      p_rprob = 70;
      repeat (200) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vx_div_sched.md
VX_DIV_SCHED -- requirements
Module: VX_div_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing one iterative divider (>=2).
REQ-002 SHALL have parameter DATAW, default 130: operand payload width (numer, denom, is_signed, rem/w flags), passed through opaquely.
REQ-003 SHALL have parameter RSPW, default 64: divider result width.
REQ-004 SHALL have parameter TAGW, default 16: per-request tag width (uuid/wid/rd etc.), returned unmodified.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQS: per-requester request valid.
REQ-008 SHALL have port req_ready, output, NUM_REQS: per-requester accept; at most one bit high per cycle.
REQ-009 SHALL have port req_data, input, NUM_REQS*DATAW: per-requester operand payload.
REQ-010 SHALL have port req_tag, input, NUM_REQS*TAGW: per-requester tag.
REQ-011 SHALL have port div_strobe, output, 1: one-cycle start pulse to the divider.
REQ-012 SHALL have port div_data, output, DATAW: operands to the divider, valid while div_strobe=1.
REQ-013 SHALL have port div_busy, input, 1: divider computing.
REQ-014 SHALL have port div_result, input, RSPW: divider result, valid when div_busy=0 after a strobe.
REQ-015 SHALL have port rsp_valid, output, 1: response valid.
REQ-016 SHALL have port rsp_ready, input, 1: response accept.
REQ-017 SHALL have port rsp_idx, output, CLOG2(NUM_REQS) (min 1): index of the originating requester.
REQ-018 SHALL have port rsp_tag, output, TAGW: tag of the originating request.
REQ-019 SHALL have port rsp_data, output, RSPW: latched result.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-021 In IDLE, SHALL grant a requester by round-robin among asserted req_valid, starting at the index after the last grantee, wrapping NUM_REQS-1 -> 0.
REQ-022 req_ready SHALL be one-hot to the grantee in IDLE when any req_valid=1, else all zero; req_ready SHALL be zero in all other states.
REQ-023 On grant (req_valid&req_ready), SHALL latch req_data, req_tag and grantee index, update the last-grantee pointer, and go to ISSUE.
REQ-024 In ISSUE, SHALL assert div_strobe=1 for exactly that cycle with div_data = latched operands, then go to WAIT.
REQ-025 div_data SHALL hold the latched operands in all states; div_strobe SHALL be 0 outside ISSUE.
REQ-026 In WAIT, SHALL ignore div_busy on the first WAIT cycle (busy-rise guard); thereafter, on a cycle with div_busy=0, SHALL latch div_result into rsp_data and go to RESP.
REQ-027 Latency: grant at cycle T -> strobe at T+1 -> with div_busy high T+2..T+1+L and low at T+2+L (L>=1) -> rsp_valid=1 at T+3+L.
REQ-028 If div_busy is already 0 on the second WAIT cycle (L=0), SHALL latch on that cycle (rsp_valid at T+4).
REQ-029 In RESP, rsp_valid=1 with rsp_idx/rsp_tag/rsp_data stable until rsp_ready=1; on acceptance SHALL return to IDLE; the next grant occurs no earlier than the following cycle.
REQ-030 Requests arriving while not IDLE SHALL stay pending (req_ready=0); requesters hold valid/data until accepted.
REQ-031 rsp_ready held low SHALL stall indefinitely in RESP without loss or change of outputs.
REQ-032 Simultaneous requests from all requesters SHALL be served in strict rotation; no requester waits more than NUM_REQS-1 other grants.

Reset
REQ-033 While reset=0 (asserted, async), SHALL force IDLE, req_ready=0, div_strobe=0, rsp_valid=0, rsp_idx/rsp_tag/rsp_data/div_data=0, last-grantee pointer=NUM_REQS-1 (requester 0 first).
REQ-034 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation with no response; after deassertion, first grant follows REQ-021 from requester 0.

Verification
REQ-035 Single request: req_valid[2]=1, tag=0x00A5, divider L=33 -> req_ready[2] at T, div_strobe at T+1, rsp_valid at T+36, rsp_idx=2, rsp_tag=0x00A5, rsp_data=div_result.
REQ-036 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one req_ready bit per IDLE cycle.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid stays 1, outputs unchanged, req_ready=0 throughout; release -> IDLE next cycle.
REQ-038 Divider busy rises one cycle late (guard case) and L=0 case -> result latched only after busy-low per REQ-026/REQ-028; no premature response.
REQ-039 Reset pulse in WAIT with req_valid[3]=1 pending -> all outputs zero immediately; after release, requester 0 (if valid) else 3 is granted, no stale response.
